// File: rtl/piece_fit_checker.sv
// piece_fit_checker
// Sequential collision checker for a proposed 4x4 tetromino placement.
// It tests the piece against the walls, the floor and the occupancy RAM.
// One piece row is scanned per cycle through a synchronous board read port.
// A registered legal/illegal verdict is returned with per-cause flags.
//
// Ports:
//   Clk, Reset          clock; asynchronous active-high reset
//   req_valid/req_ready request handshake (accepted when both high)
//   piece_mask          bit 4*r+c = cell at piece row r, column c
//   pos_x, pos_y        signed board origin of mask cell (0,0)
//   board_raddr         registered board row read address
//   board_rdata         occupancy of the addressed row, one cycle later
//   result_valid        one-cycle pulse; result fields are valid
//   legal, hit_*        verdict and cause flags, held until the next result
//
// Optional feature macro: FIT_EARLY_EXIT_EN.
//   When defined, the scan stops on the first row that raises any hit flag.
module piece_fit_checker #(
  parameter int COLS    = 10,
  parameter int ROWS    = 20,
  parameter int COORD_W = 6,
  parameter int ADDR_W  = 5
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [15:0]               piece_mask,
  input  logic signed [COORD_W-1:0] pos_x,
  input  logic signed [COORD_W-1:0] pos_y,
  output logic [ADDR_W-1:0]         board_raddr,
  input  logic [COLS-1:0]           board_rdata,
  output logic                      result_valid,
  output logic                      legal,
  output logic                      hit_left,
  output logic                      hit_right,
  output logic                      hit_floor,
  output logic                      hit_block
);

  // Two guard bits keep origin+offset arithmetic free of wrap-around.
  localparam int EW = COORD_W + 2;
  localparam logic signed [EW-1:0] COLS_S = EW'(COLS);
  localparam logic signed [EW-1:0] ROWS_S = EW'(ROWS);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                row_q, row_d;
  logic [15:0]               mask_q, mask_d;
  logic signed [COORD_W-1:0] posX_q, posX_d;
  logic signed [COORD_W-1:0] posY_q, posY_d;
  logic [ADDR_W-1:0]         raddr_q, raddr_d;
  // Flag vectors are packed {block, floor, right, left}.
  logic [3:0]                acc_q, acc_d;
  logic [3:0]                res_q, res_d;
  logic                      legal_q, legal_d;

  logic                      checkActive;
  logic [1:0]                checkRow;
  logic [3:0]                nibble;
  logic signed [EW-1:0]      rowY;
  logic signed [EW-1:0]      cellX;
  logic [3:0]                hitNow;

  // Board row address for piece row r.
  // Rows outside the board read row 0; the check stage ignores that data.
  function automatic logic [ADDR_W-1:0] rowAddr(input logic signed [COORD_W-1:0] py,
                                                input logic [1:0] r);
    logic signed [EW-1:0] y;
    y = EW'(py) + EW'(r);
    if (!y[EW-1] && (y < ROWS_S)) return ADDR_W'(y);
    return '0;
  endfunction

  // Check stage: runs one cycle behind the address stage.
  // row_q has already advanced, so the row under test is row_q-1.
  // In DRAIN, row_q has wrapped to 0, so row_q-1 is row 3.
  always_comb begin
    checkRow    = row_q - 2'd1;
    checkActive = ((state_q == SCAN) && (row_q != 2'd0)) || (state_q == DRAIN);
    nibble      = mask_q[{checkRow, 2'b00} +: 4];
    rowY        = EW'(posY_q) + EW'(checkRow);
    cellX       = '0;
    hitNow      = '0;
    if (checkActive) begin
      for (int c = 0; c < 4; c++) begin
        cellX = EW'(posX_q) + EW'(c);
        if (nibble[c]) begin
          if (cellX[EW-1]) hitNow[0] = 1'b1;
          if (cellX >= COLS_S) hitNow[1] = 1'b1;
          if (!rowY[EW-1] && (rowY >= ROWS_S)) hitNow[2] = 1'b1;
          // Rows above the board (spawn zone) never consult board_rdata.
          if (!rowY[EW-1] && (rowY < ROWS_S) && !cellX[EW-1] && (cellX < COLS_S)) begin
            for (int j = 0; j < COLS; j++) begin
              if (board_rdata[j] && (cellX == EW'(j))) hitNow[3] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Next-state logic for the scan FSM, address stage and result registers.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    mask_d  = mask_q;
    posX_d  = posX_q;
    posY_d  = posY_q;
    raddr_d = raddr_q;
    acc_d   = acc_q;
    res_d   = res_q;
    legal_d = legal_q;

    case (state_q)
      IDLE: ;
      SCAN: begin
        row_d = row_q + 2'd1;
        acc_d = acc_q | hitNow;
        if (row_q == 2'd3) state_d = DRAIN;
        else               raddr_d = rowAddr(posY_q, row_q + 2'd1);
`ifdef FIT_EARLY_EXIT_EN
        if (hitNow != 4'd0) begin
          state_d = DONE;
          res_d   = acc_q | hitNow;
          legal_d = 1'b0;
        end
`endif
      end
      DRAIN: begin
        state_d = DONE;
        res_d   = acc_q | hitNow;
        legal_d = ((acc_q | hitNow) == 4'd0);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Acceptance is only possible in IDLE or DONE.
    // It overrides the DONE->IDLE return so back-to-back requests lose no cycle.
    if (req_valid && req_ready) begin
      state_d = SCAN;
      row_d   = 2'd0;
      mask_d  = piece_mask;
      posX_d  = pos_x;
      posY_d  = pos_y;
      acc_d   = '0;
      raddr_d = rowAddr(pos_y, 2'd0);
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      mask_q  <= '0;
      posX_q  <= '0;
      posY_q  <= '0;
      raddr_q <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      legal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      mask_q  <= mask_d;
      posX_q  <= posX_d;
      posY_q  <= posY_d;
      raddr_q <= raddr_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      legal_q <= legal_d;
    end
  end

  assign req_ready    = (state_q == IDLE) || (state_q == DONE);
  assign result_valid = (state_q == DONE);
  assign board_raddr  = raddr_q;
  assign legal        = legal_q;
  assign hit_left     = res_q[0];
  assign hit_right    = res_q[1];
  assign hit_floor    = res_q[2];
  assign hit_block    = res_q[3];

endmodule

// File: tb/tb_piece_fit_checker.sv
// tb_piece_fit_checker
// Self-checking bench for piece_fit_checker.
// Directed cases cover walls, floor, blocks, the spawn zone, the empty mask,
// back-to-back requests and reset during a scan.
// These are followed by randomized placements on random boards.
// Expected values come from a cell-by-cell reference model of the placement rules.
module tb_piece_fit_checker;

  localparam int COLS    = 10;
  localparam int ROWS    = 20;
  localparam int COORD_W = 6;
  localparam int ADDR_W  = 5;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      reqValid;
  logic                      reqReady;
  logic [15:0]               pieceMask;
  logic signed [COORD_W-1:0] posX;
  logic signed [COORD_W-1:0] posY;
  logic [ADDR_W-1:0]         boardRaddr;
  logic [COLS-1:0]           boardRdata;
  logic                      resultValid;
  logic                      legal;
  logic                      hitLeft;
  logic                      hitRight;
  logic                      hitFloor;
  logic                      hitBlock;

  logic [COLS-1:0] boardMem [ROWS];

  int testsRun  = 0;
  int testsFail = 0;

  int expLat;
  int expAddr [4];
  logic expLegal, expLeft, expRight, expFloor, expBlock;

  piece_fit_checker #(
    .COLS(COLS), .ROWS(ROWS), .COORD_W(COORD_W), .ADDR_W(ADDR_W)
  ) dut (
    .Clk(clk),
    .Reset(reset),
    .req_valid(reqValid),
    .req_ready(reqReady),
    .piece_mask(pieceMask),
    .pos_x(posX),
    .pos_y(posY),
    .board_raddr(boardRaddr),
    .board_rdata(boardRdata),
    .result_valid(resultValid),
    .legal(legal),
    .hit_left(hitLeft),
    .hit_right(hitRight),
    .hit_floor(hitFloor),
    .hit_block(hitBlock)
  );

  always #5 clk = ~clk;

  // Synchronous-read occupancy RAM: data appears one cycle after the address.
  always @(posedge clk) begin
    if (int'(boardRaddr) < ROWS) boardRdata <= boardMem[boardRaddr];
    else                         boardRdata <= '0;
  end

  // Guard against a hung run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: visit every set cell of the mask, in piece-row order.
  task automatic computeExpected(input logic [15:0] m, input int px, input int py);
    bit stopped;
    bit rowHit;
    int x, y;
    expLeft  = 1'b0;
    expRight = 1'b0;
    expFloor = 1'b0;
    expBlock = 1'b0;
    expLat   = 5;
    stopped  = 1'b0;
    for (int r = 0; r < 4; r++) begin
      y = py + r;
      expAddr[r] = (y >= 0 && y < ROWS) ? y : 0;
      rowHit = 1'b0;
      if (!stopped) begin
        for (int c = 0; c < 4; c++) begin
          if (m[4*r + c]) begin
            x = px + c;
            if (x < 0)     begin expLeft  = 1'b1; rowHit = 1'b1; end
            if (x >= COLS) begin expRight = 1'b1; rowHit = 1'b1; end
            if (y >= ROWS) begin expFloor = 1'b1; rowHit = 1'b1; end
            if (y >= 0 && y < ROWS && x >= 0 && x < COLS && boardMem[y][x]) begin
              expBlock = 1'b1;
              rowHit   = 1'b1;
            end
          end
        end
`ifdef FIT_EARLY_EXIT_EN
        if (rowHit) begin
          stopped = 1'b1;
          expLat  = r + 2;
        end
`endif
      end
    end
    expLegal = !(expLeft || expRight || expFloor || expBlock);
  endtask

  // Issue one request from a negedge and follow it to its result cycle.
  // Returns at the negedge of the result cycle, so a following call is
  // accepted back-to-back from DONE.
  task automatic applyStimulus(input logic [15:0] m, input int px, input int py);
    int waitCnt;
    computeExpected(m, px, py);
    pieceMask = m;
    posX      = COORD_W'(px);
    posY      = COORD_W'(py);
    reqValid  = 1'b1;
    waitCnt   = 0;
    while (!reqReady && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!reqReady) begin
      checkOutput("req_ready timeout", 32'(reqReady), 32'd1);
      reqValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 reqValid = 1'b0;
    for (int cyc = 0; cyc <= expLat; cyc++) begin
      @(negedge clk);
      if (cyc <= 3 && cyc < expLat)
        checkOutput($sformatf("board_raddr row%0d", cyc), 32'(boardRaddr), 32'(expAddr[cyc]));
      checkOutput($sformatf("result_valid cyc%0d", cyc), 32'(resultValid), 32'(cyc == expLat));
    end
    checkOutput("legal",     32'(legal),    32'(expLegal));
    checkOutput("hit_left",  32'(hitLeft),  32'(expLeft));
    checkOutput("hit_right", 32'(hitRight), 32'(expRight));
    checkOutput("hit_floor", 32'(hitFloor), 32'(expFloor));
    checkOutput("hit_block", 32'(hitBlock), 32'(expBlock));
  endtask

  task automatic clearBoard();
    for (int y = 0; y < ROWS; y++) boardMem[y] = '0;
  endtask

  logic [15:0] shapes [7] = '{16'h0072, 16'h1111, 16'h000F, 16'h0033,
                              16'h0036, 16'h0063, 16'h0074};

  initial begin
    bit sawValid;
    int px, py;
    logic [15:0] m;

    reset     = 1'b1;
    reqValid  = 1'b0;
    pieceMask = '0;
    posX      = '0;
    posY      = '0;
    clearBoard();
    repeat (3) @(negedge clk);

    // Reset values.
    checkOutput("reset req_ready",    32'(reqReady),    32'd1);
    checkOutput("reset board_raddr",  32'(boardRaddr),  32'd0);
    checkOutput("reset result_valid", 32'(resultValid), 32'd0);
    checkOutput("reset legal",        32'(legal),       32'd0);
    checkOutput("reset hits", 32'({hitLeft, hitRight, hitFloor, hitBlock}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed placements.
    applyStimulus(16'h0072, 3, 0);
    applyStimulus(16'h1111, -1, 0);
    // The result must hold while idle.
    repeat (3) @(negedge clk);
    checkOutput("hold hit_left",     32'(hitLeft),     32'd1);
    checkOutput("hold legal",        32'(legal),       32'd0);
    checkOutput("hold result_valid", 32'(resultValid), 32'd0);
    applyStimulus(16'h000F, COLS-1, 3);
    applyStimulus(16'h0033, 4, ROWS-1);
    applyStimulus(16'h0033, 4, ROWS-2);
    boardMem[5] = 10'b0000010000;
    applyStimulus(16'h0072, 3, 4);
    applyStimulus(16'h0072, 0, 4);
    clearBoard();
    // The spawn zone must ignore the row-0 data read for off-board rows.
    boardMem[0] = '1;
    applyStimulus(16'h0033, 4, -2);
    applyStimulus(16'h0072, 3, 0);
    clearBoard();
    applyStimulus(16'h0000, 7, ROWS+5);

    // Reset during a scan.
    @(negedge clk);
    pieceMask = 16'h0072;
    posX      = 3;
    posY      = 0;
    reqValid  = 1'b1;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset req_ready",    32'(reqReady),    32'd1);
    checkOutput("midreset board_raddr",  32'(boardRaddr),  32'd0);
    checkOutput("midreset result_valid", 32'(resultValid), 32'd0);
    checkOutput("midreset legal",        32'(legal),       32'd0);
    checkOutput("midreset hits", 32'({hitLeft, hitRight, hitFloor, hitBlock}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sawValid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resultValid) sawValid = 1'b1;
    end
    checkOutput("discarded request result", 32'(sawValid), 32'd0);
    applyStimulus(16'h0072, 3, 0);

    // Randomized placements on random sparse boards.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int y = 0; y < ROWS; y++)
          boardMem[y] = COLS'($urandom & $urandom & $urandom);
      end
      if ($urandom_range(0, 3) == 0) m = 16'($urandom);
      else                           m = shapes[$urandom_range(0, 6)];
      px = int'($urandom_range(0, COLS + 4)) - 3;
      py = int'($urandom_range(0, ROWS + 5)) - 4;
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      applyStimulus(m, px, py);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
